seg7_scan_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_hex_decode.sv | 17 +
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low 7-segment pattern.
// With hex_en low, nibbles 10-15 decode to blank.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_en,
    output logic [6:0] seg_n
);

    always_comb begin
        seg_n = SEG_LUT[nibble];
        if (!hex_en && nibble > 4'd9)
            seg_n = SEG_OFF;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with double-buffered
// data, leading-zero suppression and anode dead time.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SLOT_CYC    = 50000,
    parameter int DEAD_CYC    = 2,
    parameter int HEX_EN      = 1,
    parameter int SEG_ACT_LOW = 1,
    parameter int AN_ACT_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int DW = idx_w(DIGITS);
    localparam int CW = $clog2(SLOT_CYC);

    localparam logic [CW-1:0]     SLOT_LAST = CW'(SLOT_CYC - 1);
    localparam logic [CW-1:0]     DEAD_END  = CW'(DEAD_CYC);
    localparam logic [DW-1:0]     DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF    = {DIGITS{AN_ACT_LOW != 0}};
    localparam logic [6:0]        SEG_IDLE  = (SEG_ACT_LOW != 0) ? SEG_OFF : ~SEG_OFF;
    localparam logic              DP_IDLE   = (SEG_ACT_LOW != 0);

    logic [CW-1:0]       slot_cnt;
    logic [DW-1:0]       dig_idx;
    logic                slot_wrap;
    logic                frame_wrap;

    logic [4*DIGITS-1:0] pend_val,   act_val;
    logic [DIGITS-1:0]   pend_blank, act_blank;
    logic [DIGITS-1:0]   pend_dp,    act_dp;
    logic                pend_lz,    act_lz;

    logic [DIGITS-1:0]   lz_mask;
    logic                hi_zero;
    logic [3:0]          cur_nib;
    logic [6:0]          dec_n;
    logic [6:0]          seg_n_nxt;
    logic [DIGITS-1:0]   an_on;

    assign slot_wrap  = (slot_cnt == SLOT_LAST);
    assign frame_wrap = slot_wrap && (dig_idx == DIG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            dig_idx  <= frame_wrap ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Active buffer only changes at the frame boundary, so a frame never tears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_val   <= '0;
            pend_blank <= '0;
            pend_dp    <= '0;
            pend_lz    <= 1'b0;
            act_val    <= '0;
            act_blank  <= '0;
            act_dp     <= '0;
            act_lz     <= 1'b0;
        end else begin
            if (load) begin
                pend_val   <= value;
                pend_blank <= blank;
                pend_dp    <= dp;
                pend_lz    <= lz_en;
            end
            if (frame_wrap) begin
                act_val    <= pend_val;
                act_blank  <= pend_blank;
                act_dp     <= pend_dp;
                act_lz     <= pend_lz;
            end
        end
    end

    always_comb begin
        hi_zero = 1'b1;
        lz_mask = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero    = hi_zero && (act_val[4*k +: 4] == 4'd0);
            lz_mask[k] = act_lz && hi_zero && (k != 0);
        end
    end

    assign cur_nib = act_val[{dig_idx, 2'b00} +: 4];

    seg7_hex_decode u_dec (
        .nibble (cur_nib),
        .hex_en (HEX_EN != 0),
        .seg_n  (dec_n)
    );

    always_comb begin
        seg_n_nxt = dec_n;
        if (act_blank[dig_idx] || lz_mask[dig_idx])
            seg_n_nxt = SEG_OFF;
        an_on = '0;
        if (slot_cnt >= DEAD_END)
            an_on = DIGITS'(1) << dig_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg    <= SEG_IDLE;
            dp_out <= DP_IDLE;
            an     <= AN_OFF;
            frame  <= 1'b0;
        end else begin
            seg    <= (SEG_ACT_LOW != 0) ? seg_n_nxt : ~seg_n_nxt;
            dp_out <= (SEG_ACT_LOW != 0) ? ~act_dp[dig_idx] : act_dp[dig_idx];
            an     <= (AN_ACT_LOW != 0) ? ~an_on : an_on;
            frame  <= (slot_cnt == '0) && (dig_idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a frame-level model.
// Two instances cover HEX_EN=1 and HEX_EN=0 on shared stimulus.
module tb_seg7_scan_driver;

    localparam int DIG  = 4;
    localparam int SLOT = 8;
    localparam int DEAD = 2;
    localparam int FR   = DIG * SLOT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  dp = '0;
    logic        lz_en = 1'b0;
    logic        load = 1'b0;

    logic [6:0]  seg, seg_nh;
    logic        dp_out, dp_nh;
    logic [3:0]  an, an_nh;
    logic        frame, frame_nh;

    seg7_scan_driver #(
        .DIGITS(DIG), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD),
        .HEX_EN(1), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .blank(blank),
        .dp(dp), .lz_en(lz_en), .load(load), .seg(seg),
        .dp_out(dp_out), .an(an), .frame(frame)
    );

    seg7_scan_driver #(
        .DIGITS(DIG), .SLOT_CYC(SLOT), .DEAD_CYC(DEAD),
        .HEX_EN(0), .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut_nh (
        .clk(clk), .rst_n(rst_n), .value(value), .blank(blank),
        .dp(dp), .lz_en(lz_en), .load(load), .seg(seg_nh),
        .dp_out(dp_nh), .an(an_nh), .frame(frame_nh)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          e;
        logic [15:0] v;
        logic [3:0]  b;
        logic [3:0]  d;
        logic        lz;
    } ld_t;

    ld_t lds[$];
    int  ecount;
    int  n_chk;
    int  n_fail;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic ld_t shown(input int f);
        ld_t r;
        r = '{0, 16'h0, 4'h0, 4'h0, 1'b0};
        foreach (lds[i])
            if (lds[i].e < f * FR)
                r = lds[i];
        return r;
    endfunction

    function automatic logic [6:0] exp_seg(input ld_t c, input int d,
                                           input bit hex);
        logic [3:0] nib;
        bit         zero_hi;
        nib = c.v[d*4 +: 4];
        zero_hi = 1'b1;
        for (int j = d; j < DIG; j++)
            if (c.v[j*4 +: 4] != 4'd0)
                zero_hi = 1'b0;
        if (c.b[d] || (c.lz && d > 0 && zero_hi) || (!hex && nib > 4'd9))
            return 7'h7F;
        return tbl[nib];
    endfunction

    // Output after edge e reflects scan step s = e - 1.
    task automatic step();
        int   s, f, pos, d;
        ld_t  c;
        logic [3:0] an_exp;
        @(posedge clk);
        ecount++;
        #1;
        s   = ecount - 1;
        f   = s / FR;
        pos = s % SLOT;
        d   = (s / SLOT) % DIG;
        c   = shown(f);
        an_exp = (pos < DEAD) ? 4'hF : ~(4'(1) << d);
        check("an", an, an_exp);
        check("an_nh", an_nh, an_exp);
        check("frame", frame, (s % FR) == 0);
        check("frame_nh", frame_nh, (s % FR) == 0);
        check("seg", seg, exp_seg(c, d, 1'b1));
        check("seg_nh", seg_nh, exp_seg(c, d, 1'b0));
        check("dp_out", dp_out, !c.d[d]);
        check("dp_nh", dp_nh, !c.d[d]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            step();
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] b,
                           input logic [3:0] d, input logic lz);
        value = v;
        blank = b;
        dp    = d;
        lz_en = lz;
        load  = 1'b1;
        lds.push_back('{ecount + 1, v, b, d, lz});
        step();
        load  = 1'b0;
        value = 16'($urandom);
        blank = 4'($urandom);
        dp    = 4'($urandom);
        lz_en = 1'($urandom);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_an"}, an, 4'hF);
        check({tag, "_seg"}, seg, 7'h7F);
        check({tag, "_an_nh"}, an_nh, 4'hF);
        check({tag, "_seg_nh"}, seg_nh, 7'h7F);
        check({tag, "_dp"}, dp_out, 1'b1);
        check({tag, "_frame"}, frame, 1'b0);
    endtask

    task automatic rand_load();
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < DIG; i++)
            if ($urandom_range(1, 0) == 1)
                v[i*4 +: 4] = 4'($urandom);
        do_load(v, ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0,
                4'($urandom), 1'($urandom));
    endtask

    initial begin
        ecount = 0;
        n_chk  = 0;
        n_fail = 0;

        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n  = 1'b1;
        ecount = 0;

        run(FR);
        do_load(16'h12AF, 4'h0, 4'h0, 1'b0);
        run(2 * FR);
        do_load(16'h0050, 4'h0, 4'h0, 1'b1);
        run(2 * FR);
        do_load(16'h0000, 4'h0, 4'h0, 1'b1);
        run(2 * FR);

        do_load(16'h1111, 4'h0, 4'h0, 1'b0);
        while (((ecount - 1) % FR) != FR - 1)
            step();
        run(2 * SLOT + 3);
        do_load(16'h2222, 4'h0, 4'h0, 1'b0);
        run(2 * FR);

        do_load(16'h9876, 4'b0101, 4'b0110, 1'b0);
        run(2 * FR);

        for (int i = 0; i < 40 * FR; i++) begin
            if ($urandom_range(15, 0) == 0)
                rand_load();
            else
                step();
        end

        for (int i = 0; i < 2 * FR; i++) begin
            if ((((ecount - 1) / SLOT) % DIG) == 2 &&
                ((ecount - 1) % SLOT) >= DEAD)
                break;
            step();
        end
        check("pre_rst_an", an, 4'b1011);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("async");
        repeat (2) @(posedge clk);
        #1;
        reset_checks("hold");
        rst_n  = 1'b1;
        ecount = 0;
        lds.delete();
        run(2 * FR);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
